// File: rtl/sram_multibank_ctrl.sv
// Asynchronous-SRAM controller for BANKS independent chips behind one valid/ready request port.
// Every pin output is registered; the pin values for the next cycle are derived from the next state.
module sram_multibank_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 20,
  parameter int BANKS   = 2,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [BANK_W-1:0]         req_bank,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [BE_W-1:0]           req_be,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [BANKS*ADDR_W-1:0]   ram_addr,
  output logic [BANKS*BE_W-1:0]     ram_be_n,
  output logic [BANKS-1:0]          ram_ce_n,
  output logic [BANKS-1:0]          ram_oe_n,
  output logic [BANKS-1:0]          ram_we_n,
  output logic [DATA_W-1:0]         ram_data_o,
  output logic [BANKS-1:0]          ram_data_t,
  input  logic [BANKS*DATA_W-1:0]   ram_data_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ERR
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [BANK_W:0]  NBANKS  = (BANK_W+1)'(BANKS);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [BANK_W-1:0]   bank, bank_next;
  logic [BE_W-1:0]     be, be_next;
  logic                accept;

  logic [BANKS*ADDR_W-1:0] addr_d;
  logic [BANKS*BE_W-1:0]   be_n_d;
  logic [BANKS-1:0]        ce_n_d, oe_n_d, we_n_d, data_t_d;
  logic [DATA_W-1:0]       data_o_d, rdata_d;
  logic                    rsp_valid_d, rsp_err_d;

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && (state == IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bank_next  = bank;
    be_next    = be;
    case (state)
      IDLE: begin
        if (accept) begin
          bank_next = req_bank;
          // Reads enable every byte lane, so the read path reuses the same be_n logic.
          be_next   = req_we ? req_be : '1;
          cnt_next  = '0;
          if ({1'b0, req_bank} >= NBANKS) state_next = ERR;
          else if (req_we)                state_next = WR_SETUP;
          else                            state_next = RD;
        end
      end
      RD: begin
        if (cnt == RD_LAST) state_next = IDLE;
        else                cnt_next   = cnt + 1'b1;
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
        cnt_next   = '0;
      end
      WR_PULSE: begin
        if (cnt == WR_LAST) state_next = WR_HOLD;
        else                cnt_next   = cnt + 1'b1;
      end
      WR_HOLD:  state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = ram_addr;
    data_o_d    = ram_data_o;
    rdata_d     = rsp_rdata;
    ce_n_d      = '1;
    oe_n_d      = '1;
    we_n_d      = '1;
    be_n_d      = '1;
    data_t_d    = '0;
    rsp_valid_d = (state != IDLE) && (state_next == IDLE);
    rsp_err_d   = (state == ERR);

    if (accept && state_next != ERR) begin
      addr_d = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (b == int'(bank_next)) addr_d[b*ADDR_W +: ADDR_W] = req_addr;
      end
    end
    if (accept && state_next == WR_SETUP) data_o_d = req_wdata;

    // Only the selected bank ever sees an active strobe; the others stay fully idle.
    for (int b = 0; b < BANKS; b++) begin
      if (b == int'(bank_next)) begin
        case (state_next)
          RD: begin
            ce_n_d[b]              = 1'b0;
            oe_n_d[b]              = 1'b0;
            be_n_d[b*BE_W +: BE_W] = ~be_next;
          end
          WR_SETUP, WR_HOLD: begin
            ce_n_d[b]              = 1'b0;
            be_n_d[b*BE_W +: BE_W] = ~be_next;
            data_t_d[b]            = 1'b1;
          end
          WR_PULSE: begin
            ce_n_d[b]              = 1'b0;
            we_n_d[b]              = 1'b0;
            be_n_d[b*BE_W +: BE_W] = ~be_next;
            data_t_d[b]            = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (state == RD && state_next == IDLE) rdata_d = ram_data_i[int'(bank)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bank       <= '0;
      be         <= '0;
      ram_addr   <= '0;
      ram_data_o <= '0;
      ram_ce_n   <= '1;
      ram_oe_n   <= '1;
      ram_we_n   <= '1;
      ram_be_n   <= '1;
      ram_data_t <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bank       <= bank_next;
      be         <= be_next;
      ram_addr   <= addr_d;
      ram_data_o <= data_o_d;
      ram_ce_n   <= ce_n_d;
      ram_oe_n   <= oe_n_d;
      ram_we_n   <= we_n_d;
      ram_be_n   <= be_n_d;
      ram_data_t <= data_t_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_multibank_ctrl.sv
// Directed scoreboard bench for sram_multibank_ctrl with a behavioural SRAM per bank.
// Three banks are used so that a 2-bit bank field can carry an out-of-range index (3).
module tb_sram_multibank_ctrl;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int NB = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_we;
  logic [1:0]      req_bank;
  logic [AW-1:0]   req_addr;
  logic [3:0]      req_be;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [NB*AW-1:0] ram_addr;
  logic [NB*4-1:0] ram_be_n;
  logic [NB-1:0]   ram_ce_n, ram_oe_n, ram_we_n, ram_data_t;
  logic [DW-1:0]   ram_data_o;
  logic [NB*DW-1:0] ram_data_i;

  sram_multibank_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .BANKS(NB), .RD_WAIT(1), .WR_WAIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_data_o(ram_data_o), .ram_data_t(ram_data_t), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  // SRAM model: a word is written on the clock edge that ends a cycle with ce_n and we_n low.
  logic [DW-1:0] mem [NB][64];

  always @(posedge clk) begin : mem_write
    logic [DW-1:0] w;
    for (int b = 0; b < NB; b++) begin
      if (!ram_ce_n[b] && !ram_we_n[b]) begin
        w = mem[b][ram_addr[b*AW +: 6]];
        for (int k = 0; k < 4; k++)
          if (!ram_be_n[b*4+k]) w[k*8 +: 8] = ram_data_o[k*8 +: 8];
        mem[b][ram_addr[b*AW +: 6]] <= w;
      end
    end
  end

  // Undriven read bus floats to X so sampling outside the oe_n window is caught.
  always_comb begin
    ram_data_i = '0;
    for (int b = 0; b < NB; b++) begin
      if (!ram_ce_n[b] && !ram_oe_n[b]) ram_data_i[b*DW +: DW] = mem[b][ram_addr[b*AW +: 6]];
      else                              ram_data_i[b*DW +: DW] = 'x;
    end
  end

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         cnt_ce [NB];
  int         cnt_oe [NB];
  int         cnt_we [NB];
  int         cnt_dt [NB];
  int         we_lat;
  logic [3:0] be_first;
  logic       clash;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one request, pushes its expected reply, then traces pins until the reply arrives.
  task automatic applyStimulus(input string name, input logic we, input logic [1:0] bank,
                               input logic [AW-1:0] addr, input logic [3:0] be,
                               input logic [DW-1:0] wdata, input logic exp_err,
                               input logic [DW-1:0] exp_rdata, input int exp_lat);
    rsp_t exp_rsp;
    rsp_t got_rsp;
    int   lat;
    logic got;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_bank  = bank;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    exp_rsp.err   = exp_err;
    exp_rsp.rdata = exp_rdata;
    sb.push_back(exp_rsp);
    for (int b = 0; b < NB; b++) begin
      cnt_ce[b] = 0; cnt_oe[b] = 0; cnt_we[b] = 0; cnt_dt[b] = 0;
    end
    we_lat   = -1;
    be_first = 4'hx;
    clash    = 1'b0;
    checkOutput({name, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      for (int b = 0; b < NB; b++) begin
        if (!ram_ce_n[b]) cnt_ce[b]++;
        if (!ram_oe_n[b]) cnt_oe[b]++;
        if (!ram_we_n[b]) cnt_we[b]++;
        if (ram_data_t[b]) cnt_dt[b]++;
        if (ram_data_t[b] && !ram_oe_n[b]) clash = 1'b1;
      end
      if (lat == 0 && int'(bank) < NB) be_first = ram_be_n[int'(bank)*4 +: 4];
      if (we_lat < 0 && int'(bank) < NB && !ram_we_n[bank]) we_lat = lat;
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_bus_clash"}, 64'(clash), 64'd0);
    if (got) begin
      got_rsp.err   = rsp_err;
      got_rsp.rdata = rsp_rdata;
      if (sb.size() > 0) begin
        exp_rsp = sb.pop_front();
        checkOutput({name, "_rsp_err"}, 64'(got_rsp.err), 64'(exp_rsp.err));
        checkOutput({name, "_rsp_rdata"}, 64'(got_rsp.rdata), 64'(exp_rsp.rdata));
      end else begin
        checkOutput({name, "_sb_nonempty"}, 64'd0, 64'd1);
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_rsp_single"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_bank  = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ce_n", 64'(ram_ce_n), 64'h7);
    checkOutput("rst_oe_n", 64'(ram_oe_n), 64'h7);
    checkOutput("rst_we_n", 64'(ram_we_n), 64'h7);
    checkOutput("rst_be_n", 64'(ram_be_n), 64'hFFF);
    checkOutput("rst_data_t", 64'(ram_data_t), 64'h0);
    checkOutput("rst_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_rdata", 64'(rsp_rdata), 64'h0);
    checkOutput("rst_addr", 64'(ram_addr), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_release_ready", 64'(req_ready), 64'h1);

    // Full-word write then read-back on bank 0.
    applyStimulus("wr0", 1'b1, 2'd0, 20'h00010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 3);
    checkOutput("wr0_ce_cycles", 64'(cnt_ce[0]), 64'd3);
    checkOutput("wr0_we_cycles", 64'(cnt_we[0]), 64'd1);
    checkOutput("wr0_we_position", 64'(we_lat), 64'd1);
    checkOutput("wr0_be_n", 64'(be_first), 64'h0);
    checkOutput("wr0_data_t_cycles", 64'(cnt_dt[0]), 64'd3);
    checkOutput("wr0_bank1_ce", 64'(cnt_ce[1]), 64'd0);
    checkOutput("wr0_bank1_data_t", 64'(cnt_dt[1]), 64'd0);
    applyStimulus("rd0", 1'b0, 2'd0, 20'h00010, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    checkOutput("rd0_oe_cycles", 64'(cnt_oe[0]), 64'd2);
    checkOutput("rd0_ce_cycles", 64'(cnt_ce[0]), 64'd2);
    checkOutput("rd0_data_t", 64'(cnt_dt[0]), 64'd0);
    checkOutput("rd0_be_n", 64'(be_first), 64'h0);

    // Single-byte write.
    applyStimulus("wrb", 1'b1, 2'd0, 20'h00010, 4'b0010, 32'h0000AA00, 1'b0, 32'hDEADBEEF, 3);
    checkOutput("wrb_be_n", 64'(be_first), 64'b1101);
    applyStimulus("rdb", 1'b0, 2'd0, 20'h00010, 4'h0, 32'h0, 1'b0, 32'hDEADAAEF, 2);

    // Bank 1 access leaves bank 0 idle; banks hold independent data.
    applyStimulus("wr1", 1'b1, 2'd1, 20'h00010, 4'hF, 32'h12345678, 1'b0, 32'hDEADAAEF, 3);
    checkOutput("wr1_bank0_ce", 64'(cnt_ce[0]), 64'd0);
    checkOutput("wr1_bank0_data_t", 64'(cnt_dt[0]), 64'd0);
    checkOutput("wr1_bank1_we", 64'(cnt_we[1]), 64'd1);
    applyStimulus("rd0b", 1'b0, 2'd0, 20'h00010, 4'h0, 32'h0, 1'b0, 32'hDEADAAEF, 2);
    applyStimulus("rd1", 1'b0, 2'd1, 20'h00010, 4'h0, 32'h0, 1'b0, 32'h12345678, 2);
    checkOutput("rd1_bank0_ce", 64'(cnt_ce[0]), 64'd0);
    checkOutput("rd1_bank0_oe", 64'(cnt_oe[0]), 64'd0);

    // Out-of-range bank: a single ERR cycle, no strobes, read data kept.
    applyStimulus("err", 1'b0, 2'd3, 20'h00010, 4'h0, 32'h0, 1'b1, 32'h12345678, 1);
    checkOutput("err_strobes", 64'(cnt_ce[0] + cnt_ce[1] + cnt_ce[2] + cnt_oe[0] + cnt_oe[1] + cnt_oe[2]), 64'd0);

    // Write with no byte enabled runs the full cycle but changes nothing.
    applyStimulus("wrz", 1'b1, 2'd1, 20'h00010, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h12345678, 3);
    checkOutput("wrz_be_n", 64'(be_first), 64'hF);
    checkOutput("wrz_ce_cycles", 64'(cnt_ce[1]), 64'd3);
    applyStimulus("rdz", 1'b0, 2'd1, 20'h00010, 4'h0, 32'h0, 1'b0, 32'h12345678, 2);

    // Reset during the write pulse aborts the access without a reply.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_bank  = 2'd0;
    req_addr  = 20'h00020;
    req_be    = 4'hF;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_in_pulse", 64'(ram_we_n[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we_n", 64'(ram_we_n), 64'h7);
    checkOutput("abort_ce_n", 64'(ram_ce_n), 64'h7);
    checkOutput("abort_data_t", 64'(ram_data_t), 64'h0);
    checkOutput("abort_ready", 64'(req_ready), 64'h0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    checkOutput("abort_no_rsp", 64'(seen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("wr_after", 1'b1, 2'd0, 20'h00020, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 3);
    applyStimulus("rd_after", 1'b0, 2'd0, 20'h00020, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 2);

    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
